evt_stamp_fifo: RTL and testbench

//  Downstream stage of top_pixel_hierarchy; consumes its encoded event word (data_out_o) on a valid strobe.

---
 rtl/evt_stamp_fifo.sv | 98 +++++++++
 tb/tb_evt_stamp_fifo.sv | 135 +++++++++++++
 2 files changed

// File: rtl/evt_stamp_fifo.sv
// Show-ahead event FIFO: tags arbiter events with a timestamp and group-last flag, drops and counts events when full.
// Optional timestamp counter/storage enabled by defining EVT_STAMP_TS_EN.
module evt_stamp_fifo #(
  parameter int EVT_W  = 8,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int DROP_W = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       evt_valid_i,
  input  logic [EVT_W-1:0]           evt_data_i,
  input  logic                       grp_last_i,
  output logic                       pkt_valid_o,
  input  logic                       pkt_ready_i,
  output logic [TS_W+EVT_W-1:0]      pkt_data_o,
  output logic                       pkt_last_o,
  output logic                       fifo_full_o,
  output logic                       fifo_empty_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [DROP_W-1:0]          drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef EVT_STAMP_TS_EN
  localparam int SW = TS_W + EVT_W + 1;
`else
  localparam int SW = EVT_W + 1;
`endif

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [SW-1:0]     mem_q [DEPTH];
  logic [SW-1:0]     wdata, head;
  logic [TS_W-1:0]   head_ts;
  logic              full, empty, push, pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign pop   = !empty && pkt_ready_i;
  assign push  = evt_valid_i && (!full || pop);

`ifdef EVT_STAMP_TS_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ts_q <= '0;
    else         ts_q <= ts_q + TS_W'(1);
  end

  assign wdata   = {ts_q, evt_data_i, grp_last_i};
  assign head_ts = head[SW-1 -: TS_W];
`else
  assign wdata   = {evt_data_i, grp_last_i};
  assign head_ts = '0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
    // Arbiter cannot be stalled, so a rejected event is lost; count saturates.
    if (evt_valid_i && !push && drop_q != '1) drop_d = drop_q + DROP_W'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head         = mem_q[rd_ptr_q];
  assign pkt_valid_o  = !empty;
  assign pkt_data_o   = empty ? '0 : {head_ts, head[EVT_W:1]};
  assign pkt_last_o   = !empty && head[0];
  assign fifo_full_o  = full;
  assign fifo_empty_o = empty;
  assign level_o      = level_q;
  assign drop_cnt_o   = drop_q;
endmodule

// File: tb/tb_evt_stamp_fifo.sv
// Directed + random bench for evt_stamp_fifo against a queue-based reference model.
module tb_evt_stamp_fifo;
  localparam int EVT_W = 8, DEPTH = 16, TS_W = 16, DROP_W = 8;

  logic                  clk_i = 0, reset_i = 1;
  logic                  evt_valid_i = 0, grp_last_i = 0, pkt_ready_i = 0;
  logic [EVT_W-1:0]      evt_data_i = '0;
  logic                  pkt_valid_o, pkt_last_o, fifo_full_o, fifo_empty_o;
  logic [TS_W+EVT_W-1:0] pkt_data_o;
  logic [$clog2(DEPTH):0] level_o;
  logic [DROP_W-1:0]     drop_cnt_o;

  evt_stamp_fifo #(.EVT_W(EVT_W), .DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .evt_valid_i(evt_valid_i), .evt_data_i(evt_data_i),
    .grp_last_i(grp_last_i), .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
    .pkt_data_o(pkt_data_o), .pkt_last_o(pkt_last_o), .fifo_full_o(fifo_full_o),
    .fifo_empty_o(fifo_empty_o), .level_o(level_o), .drop_cnt_o(drop_cnt_o));

  always #5 clk_i = ~clk_i;

  // Reference model: queue of {ts, event, last} plus cycle counter and drop count.
  typedef struct { int unsigned ts; int unsigned evt; bit last; } ent_t;
  ent_t        q[$];
  int unsigned ts_m, drop_m;
  int          n_total = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] exp_data(input ent_t e);
`ifdef EVT_STAMP_TS_EN
    return {40'd0, e.ts[TS_W-1:0], e.evt[EVT_W-1:0]};
`else
    return {56'd0, e.evt[EVT_W-1:0]};
`endif
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 64'(pkt_valid_o), 64'(q.size() != 0));
    check({tag, ".level"}, 64'(level_o), 64'(q.size()));
    check({tag, ".full"}, 64'(fifo_full_o), 64'(q.size() == DEPTH));
    check({tag, ".empty"}, 64'(fifo_empty_o), 64'(q.size() == 0));
    check({tag, ".drop"}, 64'(drop_cnt_o), 64'(drop_m));
    check({tag, ".data"}, 64'(pkt_data_o), q.size() != 0 ? exp_data(q[0]) : 64'd0);
    check({tag, ".last"}, 64'(pkt_last_o), 64'(q.size() != 0 && q[0].last));
  endtask

  // One clock cycle: drive inputs, check pre-edge state, advance model, pass the edge.
  task automatic step(input string tag, input bit v, input int unsigned d, input bit gl, input bit rdy);
    bit do_pop, was_full;
    ent_t e;
    evt_valid_i = v; evt_data_i = d[EVT_W-1:0]; grp_last_i = gl; pkt_ready_i = rdy;
    #1;
    check_outputs(tag);
    was_full = (q.size() == DEPTH);
    do_pop   = (q.size() != 0) && rdy;
    e.ts = ts_m; e.evt = d & ((1 << EVT_W) - 1); e.last = gl;
    if (do_pop) void'(q.pop_front());
    if (v) begin
      if (!was_full || do_pop) q.push_back(e);
      else if (drop_m < (1 << DROP_W) - 1) drop_m++;
    end
    @(posedge clk_i); #1;
    ts_m = (ts_m + 1) % (1 << TS_W);
  endtask

  task automatic do_reset(input string tag);
    reset_i = 1;
    #1;
    q.delete(); drop_m = 0; ts_m = 0;
    check_outputs(tag);
    @(posedge clk_i); #1;
    reset_i = 0;
    evt_valid_i = 0; grp_last_i = 0; pkt_ready_i = 0;
  endtask

  initial begin
    ts_m = 0; drop_m = 0;
    // 1: reset and idle
    do_reset("rst");
    for (int i = 0; i < 20; i++) step("idle", 0, 0, 0, 0);

    // 2: single event at ts 5 with ready held high
    do_reset("rst2");
    for (int i = 0; i < 5; i++) step("pre", 0, 0, 0, 1);
    step("single_push", 1, 'h2A, 0, 1);
`ifdef EVT_STAMP_TS_EN
    check("single_const", 64'(pkt_data_o), 64'({16'd5, 8'h2A}));
`else
    check("single_const", 64'(pkt_data_o), 64'({16'd0, 8'h2A}));
`endif
    step("single_pop", 0, 0, 0, 1);
    step("single_after", 0, 0, 0, 1);

    // 3: fill, overflow by 3, drain
    for (int i = 0; i < DEPTH; i++) step("fill", 1, $urandom, 0, 0);
    for (int i = 0; i < 3; i++) step("ovf", 1, $urandom, 0, 0);
    check("ovf_drop", 64'(drop_cnt_o), 64'd3);
    check("ovf_level", 64'(level_o), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) step("drain", 0, 0, 0, 1);

    // 4: full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) step("fill2", 1, $urandom, 0, 0);
    step("full_pp", 1, 'h77, 0, 1);
    check("full_pp_level", 64'(level_o), 64'(DEPTH));
    check("full_pp_drop", 64'(drop_cnt_o), 64'd3);
    for (int i = 0; i < DEPTH; i++) step("drain2", 0, 0, 0, 1);

    // 5: group-last with event, then alone
    step("gl_evt", 1, 'h5C, 1, 0);
    step("gl_alone", 0, 'h11, 1, 0);
    check("gl_level", 64'(level_o), 64'd1);
    check("gl_last", 64'(pkt_last_o), 64'd1);
    step("gl_pop", 0, 0, 0, 1);

    // 6: reset mid-stream with 7 entries
    for (int i = 0; i < 7; i++) step("pre_rst", 1, $urandom, $urandom_range(0, 1), 0);
    do_reset("mid_rst");

    // Randomized traffic with varying pressure
    for (int i = 0; i < 600; i++) begin
      bit v, r;
      v = ($urandom_range(0, 99) < (i < 300 ? 80 : 40));
      r = ($urandom_range(0, 99) < (i < 300 ? 30 : 70));
      step("rand", v, $urandom, $urandom_range(0, 1), r);
    end
    for (int i = 0; i < DEPTH + 2; i++) step("final", 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
